// File: rtl/pixel_frame_streamer.sv
// Ping-pong frame buffer: loads pixel bytes from an upstream source and replays one frame per request.
// Latency: start at edge k with a full bank and ready downstream -> first valid_out at edge k+3.
// Backpressure: wr_ready drops while the write bank is full; downstream_ready is only sampled before a frame starts.
module pixel_frame_streamer #(
   parameter int IMG_PIXELS = 784,
   parameter int ADDR_W     = 10,
   parameter int GAP_CYCLES = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_valid,
   input  logic [7:0] wr_data,
   output logic       wr_ready,
   input  logic       start,
   input  logic       downstream_ready,
   output logic       valid_out,
   output logic [7:0] pixel_out,
   output logic       busy,
   output logic       frame_done,
   output logic [1:0] frames_full
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WAIT_RDY = 3'd1;
   localparam logic [2:0] S_STREAM   = 3'd2;
   localparam logic [2:0] S_GAP      = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_PIXELS - 1);
   localparam logic [ADDR_W:0]   BANK1_BASE = (ADDR_W + 1)'(IMG_PIXELS);
   localparam logic [15:0]       GAP_M1     = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   // Two frames back to back: bank0 at 0, bank1 at IMG_PIXELS.
   logic [7:0]        mem [2*IMG_PIXELS];

   logic [ADDR_W-1:0] wr_ptr;
   logic              wr_bank;
   logic              rd_bank;
   logic [ADDR_W-1:0] rd_addr;
   logic              pending;
   logic [2:0]        state;
   logic [15:0]       gap_cnt;

   logic              wr_fire;
   logic              wr_last;
   logic [ADDR_W:0]   wr_idx;
   logic [ADDR_W:0]   rd_idx;
   logic [1:0]        full_set;
   logic [1:0]        full_clr;

   assign wr_ready = ~frames_full[wr_bank];
   assign wr_fire  = wr_valid && wr_ready;
   assign wr_last  = wr_fire && (wr_ptr == LAST_ADDR);
   assign wr_idx   = (wr_bank ? BANK1_BASE : {(ADDR_W + 1){1'b0}}) + {1'b0, wr_ptr};
   assign rd_idx   = (rd_bank ? BANK1_BASE : {(ADDR_W + 1){1'b0}}) + {1'b0, rd_addr};

   // A bank is marked full by its last byte and released by the DONE state of its replay.
   assign full_set = wr_last ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
   assign full_clr = (state == S_DONE) ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

   // Pixel storage; no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (rst_n && wr_fire) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Write pointer walks the frame in raster order, then flips to the other bank.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         wr_bank <= 1'b0;
      end else if (wr_fire) begin
         if (wr_ptr == LAST_ADDR) begin
            wr_ptr  <= '0;
            wr_bank <= ~wr_bank;
         end else begin
            wr_ptr <= wr_ptr + 1'b1;
         end
      end
   end

   // Per-bank full flags; set and clear never target the same bank on one edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frames_full <= 2'b00;
      end else begin
         frames_full <= (frames_full & ~full_clr) | full_set;
      end
   end

   // Request/replay FSM: registered read data drives valid_out/pixel_out directly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         pending    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         valid_out  <= 1'b0;
         pixel_out  <= 8'd0;
         rd_bank    <= 1'b0;
         rd_addr    <= '0;
         gap_cnt    <= '0;
      end else begin
         frame_done <= 1'b0;
         valid_out  <= 1'b0;
         if (start && !pending && !busy) begin
            pending <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               // Request waits here until the read bank holds a complete frame.
               if (pending && frames_full[rd_bank]) begin
                  pending <= 1'b0;
                  busy    <= 1'b1;
                  state   <= S_WAIT_RDY;
               end
            end
            S_WAIT_RDY: begin
               if (downstream_ready) begin
                  rd_addr <= '0;
                  state   <= S_STREAM;
               end
            end
            S_STREAM: begin
               valid_out <= 1'b1;
               pixel_out <= mem[rd_idx];
               if (rd_addr == LAST_ADDR) begin
                  state <= S_DONE;
               end else if (GAP_CYCLES == 0) begin
                  rd_addr <= rd_addr + 1'b1;
               end else begin
                  gap_cnt <= GAP_M1;
                  state   <= S_GAP;
               end
            end
            S_GAP: begin
               // Final gap cycle issues the next address so pulses land 1+GAP_CYCLES apart.
               if (gap_cnt == 16'd0) begin
                  rd_addr <= rd_addr + 1'b1;
                  state   <= S_STREAM;
               end else begin
                  gap_cnt <= gap_cnt - 16'd1;
               end
            end
            S_DONE: begin
               frame_done <= 1'b1;
               busy       <= 1'b0;
               rd_bank    <= ~rd_bank;
               state      <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_frame_streamer.sv
// Bench for pixel_frame_streamer: scoreboarded replay of loaded frames plus latency/flag checks.
// Latency: expectations are edge indices counted from the start-sampling edge.
// Backpressure: loader honours wr_ready; a second instance covers the gapped stream.
module tb_pixel_frame_streamer;

   localparam int IMG = 784;

   logic       clk;
   logic       rst_n;
   logic       g_rst_n;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic       start;
   logic       downstream_ready;
   logic       valid_out;
   logic [7:0] pixel_out;
   logic       busy;
   logic       frame_done;
   logic [1:0] frames_full;

   logic       g_wr_ready;
   logic       g_start;
   logic       g_valid_out;
   logic [7:0] g_pixel_out;
   logic       g_busy;
   logic       g_frame_done;
   logic [1:0] g_frames_full;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] exp_q[$];
   int beats, first_cyc, last_cyc, done_cnt, done_cyc;
   int g_beats, g_first, g_prev, g_bad_space, g_done_cnt, g_done_cyc;

   pixel_frame_streamer #(.IMG_PIXELS(IMG), .ADDR_W(10), .GAP_CYCLES(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .start(start), .downstream_ready(downstream_ready), .valid_out(valid_out),
      .pixel_out(pixel_out), .busy(busy), .frame_done(frame_done), .frames_full(frames_full)
   );

   pixel_frame_streamer #(.IMG_PIXELS(IMG), .ADDR_W(10), .GAP_CYCLES(2)) u_gap (
      .clk(clk), .rst_n(g_rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(g_wr_ready),
      .start(g_start), .downstream_ready(1'b1), .valid_out(g_valid_out),
      .pixel_out(g_pixel_out), .busy(g_busy), .frame_done(g_frame_done), .frames_full(g_frames_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Main stream monitor: pops the scoreboard on every valid beat.
   always @(posedge clk) begin
      logic [7:0] e;
      #1;
      if (valid_out) begin
         if (beats == 0) first_cyc = cyc;
         last_cyc = cyc;
         beats++;
         if (exp_q.size() == 0) begin
            chk("unexpected_pixel", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("pixel", {24'd0, pixel_out}, {24'd0, e});
         end
      end
      if (frame_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   // Gapped instance monitor: pixel value model is index mod 256, spacing must be 3.
   always @(posedge clk) begin
      #1;
      if (g_valid_out) begin
         if (g_beats == 0) g_first = cyc;
         else if (cyc - g_prev != 3) g_bad_space++;
         chk("gap_pixel", {24'd0, g_pixel_out}, {24'd0, 8'(g_beats)});
         g_prev = cyc;
         g_beats++;
      end
      if (g_frame_done) begin
         g_done_cnt++;
         g_done_cyc = cyc;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "bench timeout");
   end

   task automatic clear_stats();
      beats = 0; first_cyc = 0; last_cyc = 0; done_cnt = 0; done_cyc = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
      chk("rst_pixel_out", {24'd0, pixel_out}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      chk("rst_frames_full", {30'd0, frames_full}, 32'd0);
      chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic pulse_start(output int k);
      k = cyc + 1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // mode 0: value = index mod 256; mode 1: constant val. Returns stall cycles and last accept edge.
   task automatic load_frame(input int mode, input logic [7:0] val, output int stalls, output int last_edge);
      int w;
      stalls = 0;
      last_edge = 0;
      for (int i = 0; i < IMG; i++) begin
         wr_valid = 1'b1;
         wr_data  = (mode != 0) ? val : 8'(i);
         w = 0;
         while (!wr_ready && w < 20000) begin
            @(negedge clk);
            w++;
            stalls++;
         end
         if (!wr_ready) begin
            chk("wr_stall_timeout", 32'd0, 32'd1);
            wr_valid = 1'b0;
            return;
         end
         exp_q.push_back(wr_data);
         last_edge = cyc + 1;
         @(negedge clk);
      end
      wr_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n;
      n = 0;
      while (done_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("frame_done_timeout", {31'd0, done_cnt >= target}, 32'd1);
   endtask

   task automatic pulse_while_busy();
      int n;
      n = 0;
      while (!busy && n < 4000) begin
         @(negedge clk);
         n++;
      end
      chk("t4_busy_seen", {31'd0, busy}, 32'd1);
      repeat (3) begin
         repeat (100) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   initial begin
      int k, e, stalls, w_edge, n;
      rst_n = 1'b0; g_rst_n = 1'b0;
      wr_valid = 1'b0; wr_data = 8'd0;
      start = 1'b0; g_start = 1'b0; downstream_ready = 1'b0;
      g_beats = 0; g_first = 0; g_prev = 0; g_bad_space = 0; g_done_cnt = 0; g_done_cyc = 0;
      clear_stats();
      @(negedge clk);
      do_reset();

      // 1: ramp frame, ready downstream, first beat 3 edges after start.
      load_frame(0, 8'h00, stalls, w_edge);
      chk("t1_full_after_load", {30'd0, frames_full}, 32'd1);
      chk("t1_wr_ready_bank1", {31'd0, wr_ready}, 32'd1);
      downstream_ready = 1'b1;
      pulse_start(k);
      wait_done(1, 2000);
      chk("t1_first_beat", first_cyc, k + 3);
      chk("t1_last_beat", last_cyc, k + 3 + IMG - 1);
      chk("t1_beats", beats, IMG);
      chk("t1_done_edge", done_cyc, k + 3 + IMG);
      chk("t1_full_cleared", {30'd0, frames_full}, 32'd0);
      chk("t1_busy_low", {31'd0, busy}, 32'd0);
      chk("t1_queue_empty", exp_q.size(), 32'd0);

      // 2: downstream held off for 500 cycles.
      clear_stats();
      downstream_ready = 1'b0;
      load_frame(0, 8'h00, stalls, w_edge);
      pulse_start(k);
      repeat (500) @(negedge clk);
      chk("t2_busy_waiting", {31'd0, busy}, 32'd1);
      chk("t2_no_beats", beats, 32'd0);
      downstream_ready = 1'b1;
      e = cyc + 1;
      wait_done(1, 2000);
      chk("t2_first_beat", first_cyc, e + 1);
      chk("t2_beats", beats, IMG);
      chk("t2_contiguous", last_cyc - first_cyc, IMG - 1);

      // 3: second frame loads during replay; both full blocks the writer.
      clear_stats();
      load_frame(1, 8'h11, stalls, w_edge);
      pulse_start(k);
      load_frame(1, 8'h22, stalls, w_edge);
      chk("t3_b_no_stall", stalls, 32'd0);
      chk("t3_both_full", {30'd0, frames_full}, 32'd3);
      chk("t3_wr_ready_low", {31'd0, wr_ready}, 32'd0);
      chk("t3_a_not_done", done_cnt, 32'd0);
      wait_done(1, 2000);
      chk("t3_wr_ready_after_done", {31'd0, wr_ready}, 32'd1);
      chk("t3_bank1_still_full", {30'd0, frames_full}, 32'd2);
      pulse_start(k);
      wait_done(2, 2000);
      chk("t3_beats", beats, 2 * IMG);
      chk("t3_queue_empty", exp_q.size(), 32'd0);

      // 4: request before any data; stream starts itself after the last byte.
      clear_stats();
      pulse_start(k);
      repeat (20) @(negedge clk);
      chk("t4_idle_busy", {31'd0, busy}, 32'd0);
      chk("t4_idle_beats", beats, 32'd0);
      fork
         load_frame(0, 8'h00, stalls, w_edge);
         pulse_while_busy();
      join
      wait_done(1, 2000);
      chk("t4_first_beat", first_cyc, w_edge + 3);
      repeat (900) @(negedge clk);
      chk("t4_single_frame", done_cnt, 32'd1);
      chk("t4_beats", beats, IMG);
      chk("t4_busy_low", {31'd0, busy}, 32'd0);

      // 6: reset in the middle of a replay.
      clear_stats();
      load_frame(0, 8'h00, stalls, w_edge);
      pulse_start(k);
      n = 0;
      while (beats < 400 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("t6_reached_400", beats, 32'd400);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_valid_dropped", {31'd0, valid_out}, 32'd0);
      chk("t6_full_cleared", {30'd0, frames_full}, 32'd0);
      chk("t6_wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("t6_no_frame_done", done_cnt, 32'd0);
      chk("t6_no_more_beats", beats, 32'd400);
      clear_stats();
      load_frame(0, 8'h00, stalls, w_edge);
      pulse_start(k);
      wait_done(1, 2000);
      chk("t6_fresh_first", first_cyc, k + 3);
      chk("t6_fresh_beats", beats, IMG);

      // 5: gapped instance, pulses every 3 cycles.
      do_reset();
      g_rst_n = 1'b1;
      clear_stats();
      load_frame(0, 8'h00, stalls, w_edge);
      exp_q.delete();
      k = cyc + 1;
      g_start = 1'b1;
      @(negedge clk);
      g_start = 1'b0;
      n = 0;
      while (g_done_cnt < 1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      chk("t5_done_seen", g_done_cnt, 32'd1);
      chk("t5_first_beat", g_first, k + 3);
      chk("t5_beats", g_beats, IMG);
      chk("t5_spacing", g_bad_space, 32'd0);
      // Last pulse at +2349; frame_done follows on the next cycle (2351st counting the first pulse as 1).
      chk("t5_done_offset", g_done_cyc - g_first, 32'd2350);
      chk("t5_main_quiet", beats, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
